// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control path for a 5-stage RV32 pipeline.
//   Decodes the ID-stage opcode into a control bundle and carries it through
//   ID/EX, EX/MEM and MEM/WB registers. Inserts LOAD_USE_STALL bubbles on a
//   load-use hazard, squashes ID on a taken branch, and freezes on stall_ext_i.
// Ports:
//   clk_i, rst_i (async, active-low)
//   op_i, rs1_addr_i, rs2_addr_i, rd_addr_i   ID-stage instruction fields
//   branch_taken_i, stall_ext_i               EX branch outcome, global hold
//   pc_write_o, ifid_write_o, ifid_flush_o    front-end control
//   illegal_op_o                              unsupported opcode in ID
//   ex_*  ID/EX outputs, mem_* EX/MEM outputs, wb_* MEM/WB outputs
module pipe_ctrl_unit #(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned ALUOP_W        = 2,
    parameter int unsigned LOAD_USE_STALL = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [6:0]            op_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  branch_taken_i,
    input  logic                  stall_ext_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  illegal_op_o,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_branch_o,
    output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o,
    output logic [REG_ADDR_W-1:0] wb_rd_addr_o
);

    typedef enum logic {RUN, STALL} state_t;

    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic                  alusrc;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  memtoreg;
        logic                  branch;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic                  memread;
        logic                  memwrite;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
    } memwb_t;

    idex_t  idex_q, idex_d, dec;
    exmem_t exmem_q;
    memwb_t memwb_q;
    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic illegal, rs1_used, rs2_used, hz;

    // Opcode decode; an unsupported opcode yields a bubble (rd forced to 0).
    always_comb begin
        dec      = '0;
        illegal  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (op_i)
            7'b0110011: begin
                dec.aluop = ALUOP_W'(2'b10); dec.regwrite = 1'b1;
                dec.rd = rd_addr_i; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            7'b0010011: begin
                dec.aluop = ALUOP_W'(2'b11); dec.alusrc = 1'b1; dec.regwrite = 1'b1;
                dec.rd = rd_addr_i; rs1_used = 1'b1;
            end
            7'b0000011: begin
                dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1;
                dec.memtoreg = 1'b1; dec.rd = rd_addr_i; rs1_used = 1'b1;
            end
            7'b0100011: begin
                dec.alusrc = 1'b1; dec.memwrite = 1'b1;
                dec.rd = rd_addr_i; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            7'b1100011: begin
                dec.aluop = ALUOP_W'(2'b01); dec.branch = 1'b1;
                dec.rd = rd_addr_i; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign hz = idex_q.memread && (idex_q.rd != '0) &&
                ((rs1_used && (rs1_addr_i == idex_q.rd)) ||
                 (rs2_used && (rs2_addr_i == idex_q.rd)));

    // Front-end control and next state. Priority: reset, hold, branch,
    // ongoing stall, new hazard, normal run.
    always_comb begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        illegal_op_o = rst_i && !stall_ext_i && illegal;
        idex_d       = dec;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (!rst_i || stall_ext_i) begin
            idex_d = idex_q;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            idex_d       = '0;
            state_d      = RUN;
            cnt_d        = '0;
        end else if (state_q == STALL) begin
            idex_d = '0;
            cnt_d  = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = RUN;
        end else if (hz) begin
            idex_d = '0;
            if (LOAD_USE_STALL > 1) begin
                state_d = STALL;
                cnt_d   = 2'(LOAD_USE_STALL - 1);
            end
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (!stall_ext_i) begin
            idex_q  <= idex_d;
            exmem_q <= '{memread: idex_q.memread, memwrite: idex_q.memwrite,
                         regwrite: idex_q.regwrite, memtoreg: idex_q.memtoreg,
                         rd: idex_q.rd};
            memwb_q <= '{regwrite: exmem_q.regwrite, memtoreg: exmem_q.memtoreg,
                         rd: exmem_q.rd};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_aluop_o    = idex_q.aluop;
    assign ex_alusrc_o   = idex_q.alusrc;
    assign ex_branch_o   = idex_q.branch;
    assign ex_rd_addr_o  = idex_q.rd;
    assign mem_read_o    = exmem_q.memread;
    assign mem_write_o   = exmem_q.memwrite;
    assign wb_regwrite_o = memwb_q.regwrite;
    assign wb_memtoreg_o = memwb_q.memtoreg;
    assign wb_rd_addr_o  = memwb_q.rd;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised pipelined control unit for the 5-stage RV32 core.
- Decodes the ID-stage opcode into a control bundle and carries it through registered ID/EX, EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts a configurable number of bubbles.
- Squashes the ID instruction on a taken branch, and honours a global external hold.

Parameters:
- REG_ADDR_W, 5: register address width.
- ALUOP_W, 2: ALUOp field width. Values ≥2 are legal; codes are zero-extended.
- LOAD_USE_STALL, 1: number of bubbles inserted per load-use hazard. Legal range 1..3.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- op_i  in  7  ID-stage opcode.
- rs1_addr_i  in  REG_ADDR_W  ID-stage rs1.
- rs2_addr_i  in  REG_ADDR_W  ID-stage rs2.
- rd_addr_i  in  REG_ADDR_W  ID-stage rd.
- branch_taken_i  in  1  branch currently in EX resolved taken.
- stall_ext_i  in  1  global hold, e.g. memory busy.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  clear IF/ID register.
- illegal_op_o  out  1  unsupported opcode in ID this cycle.
- ex_aluop_o  out  ALUOP_W  ID/EX ALUOp.
- ex_alusrc_o  out  1  ID/EX ALUSrc.
- ex_branch_o  out  1  ID/EX branch.
- ex_rd_addr_o  out  REG_ADDR_W  ID/EX rd.
- mem_read_o  out  1  EX/MEM MemRead.
- mem_write_o  out  1  EX/MEM MemWrite.
- wb_regwrite_o  out  1  MEM/WB RegWrite.
- wb_memtoreg_o  out  1  MEM/WB MemtoReg.
- wb_rd_addr_o  out  REG_ADDR_W  MEM/WB rd.

Behaviour:
- Decode table (combinational; fields are aluop, alusrc, regwrite, memread, memwrite, memtoreg, branch):
  - R-type 0110011 → 10, 0, 1, 0, 0, 0, 0.
  - I-ALU 0010011 → 11, 1, 1, 0, 0, 0, 0.
  - LW 0000011 → 00, 1, 1, 1, 0, 1, 0.
  - SW 0100011 → 00, 1, 0, 0, 1, 0, 0.
  - BEQ 1100011 → 01, 0, 0, 0, 0, 0, 1.
  - Any other opcode → all fields 0 and illegal_op_o=1. illegal_op_o is forced to 0 during a hold.
- Bubble: an all-zero bundle with rd=0.
- Stage registers: on every edge with stall_ext_i=0:
  - ID/EX ← decoded bundle or bubble.
  - EX/MEM ← ID/EX.
  - MEM/WB ← EX/MEM.
  - With stall_ext_i=1 all stage registers, FSM state and counter hold.
- Register usage: rs1 is used by R, I, LW, SW, BEQ. rs2 is used by R, SW, BEQ.
- Hazard condition: hz = ID/EX memread & (ex_rd≠0) & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
- FSM states: RUN, STALL. Counter cnt is 2 bits.
  - RUN, hz=0: pc_write=ifid_write=1; ID/EX ← decoded.
  - RUN, hz=1: pc_write=ifid_write=0; ID/EX ← bubble. If LOAD_USE_STALL>1, go STALL with cnt=LOAD_USE_STALL-1; otherwise stay RUN.
  - STALL: pc_write=ifid_write=0; ID/EX ← bubble; cnt decrements. Return to RUN when cnt==1 at the edge.
  - Total bubbles per hazard = LOAD_USE_STALL.
- Branch (branch_taken_i=1, stall_ext_i=0), in any state:
  - ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
  - ID/EX ← bubble.
  - FSM → RUN, cnt ← 0.
  - Branch has priority over hazard and STALL.
- Hold (stall_ext_i=1): pc_write_o=ifid_write_o=ifid_flush_o=0, and branch_taken_i is ignored. The EX stage also holds, so the source re-presents the branch after the hold.
- Reset (rst_i=0, asynchronous, any time including mid-STALL):
  - All stage registers are cleared to bubble.
  - FSM → RUN, cnt=0.
  - pc_write_o, ifid_write_o, ifid_flush_o and illegal_op_o are forced to 0 while rst_i=0.
- Latency:
  - Decode → ex_* : 1 edge.
  - → mem_* : 2 edges.
  - → wb_* : 3 edges.
- rd=x0 never triggers a hazard.

Test Plan:
- Reset then R-type (op 0110011, rd=5) → after 1 edge ex_aluop_o=10, ex_alusrc_o=0; after 3 edges wb_regwrite_o=1, wb_rd_addr_o=5.
- LW x3 followed by ADD using rs1=3, LOAD_USE_STALL=1 → exactly one cycle with pc_write_o=ifid_write_o=0 and one bubble. With LOAD_USE_STALL=3 → three stall cycles, then RUN.
- LW x0 followed by use of rs1=0 → no stall. SW with rs2 matching ex_rd → stall. I-ALU whose rs2 field matches ex_rd → no stall.
- branch_taken_i pulse during cycle 2 of a LOAD_USE_STALL=3 stall → ifid_flush_o=1, pc_write_o=1, FSM in RUN next cycle, ID/EX is a bubble.
- stall_ext_i=1 for 4 cycles mid-pipeline → all ex/mem/wb outputs frozen and pc_write_o=0; pipeline resumes unchanged after release.
- op_i=1111111 → illegal_op_o=1 and a bubble propagates. rst_i pulsed low mid-STALL → all outputs 0 asynchronously, RUN after release.
